regfile_wb_arbiter: RTL

Shares the register file's single write port (we/waddr/wdata) between NUM_REQ writeback requesters, e.g. ALU, load unit and multiplier.
- Round-robin arbitration with a valid/ready handshake per requester.
- One grant per cycle; the winner is registered onto the write port.
- Sits between the execute/memory stages and the register file; honours the global rdy pause.

---
 rtl/regfile_wb_arbiter_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_rr_pick.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the writeback arbiter
//   WB_REQ_NUM   : default number of writeback requesters
//   REG_ADDR_W   : register address bus width
//   DATA_W_DEF   : data bus width
//   ENABLE/DISABLE, ZERO_WORD : common control constants
//   ptr_width()  : width of the round-robin pointer / requester index bus
package regfile_wb_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int WB_REQ_NUM = 3;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  // Requester index bus width: clog2(n), never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// rtl/regfile_wb_arbiter_rr_pick.sv - combinational round-robin picker
//   req   : request vector
//   ptr   : highest-priority index for this cycle
//   grant : one-hot winner (zero when no request)
//   idx   : encoded winner index
//   any   : at least one request present
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  // Scan ptr, ptr+1, ... wrapping at N; the first valid request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = PW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register file write port
//   clk, rst (async, active-high), rdy (global run enable)
//   req_valid/req_addr/req_data : per-requester writeback requests (slice i = requester i)
//   req_ready                   : one-hot combinational grant
//   we/waddr/wdata              : registered register file write port
//   Optional (WBARB_PERF_CNT_EN): grant_cnt (32 bits per requester), conflict_cnt
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = WB_REQ_NUM,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata
`ifdef WBARB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0]     grant_cnt,
  output logic [31:0]               conflict_cnt
`endif
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               take;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grants are suppressed while paused or held in reset so nothing is consumed.
  assign req_ready = (rdy && !rst) ? pick_grant : '0;
  assign take      = rdy && !rst && pick_any;
  assign sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we     <= DISABLE;
      waddr  <= '0;
      wdata  <= '0;
      rr_ptr <= '0;
    end else if (rdy) begin
      if (take) begin
        rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        // Writes to x0 are consumed but never reach the register file.
        if (sel_addr != '0) begin
          we    <= ENABLE;
          waddr <= sel_addr;
          wdata <= sel_data;
        end else begin
          we <= DISABLE;
        end
      end else begin
        we <= DISABLE;
      end
    end
  end

`ifdef WBARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) begin
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if ($countones(req_valid) >= 2) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
